// File: rtl/wb_arb.sv
// Two-initiator Wishbone arbiter: round-robin grant with a one-cycle gap between owners, no preemption.
// Optional macro WB_ARB_TIMEOUT_EN adds per-initiator err outputs driven by a strobe watchdog.
module wb_arb #(
    parameter int AW  = 30,
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic [DW-1:0]   m0_dat_o,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic [DW-1:0]   m1_dat_o,
`ifdef WB_ARB_TIMEOUT_EN
    output logic            m0_err_o,
    output logic            m1_err_o,
`endif
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [DW/8-1:0] sel_o,
    output logic [AW-1:0]   adr_o,
    output logic [DW-1:0]   dat_o,
    input  logic            ack_i,
    input  logic [DW-1:0]   dat_i
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_nx;
    logic   last, last_nx;   // 1: m1 was granted most recently
    logic   stb_req;
    logic   tmo_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    state_nx = GNT0;
                    last_nx  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_nx = GNT1;
                    last_nx  = 1'b1;
                end
            end
            GNT0:    if (!m0_cyc_i) state_nx = IDLE;
            GNT1:    if (!m1_cyc_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cyc_o    = 1'b0;
        stb_req  = 1'b0;
        we_o     = 1'b0;
        sel_o    = '0;
        adr_o    = '0;
        dat_o    = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            GNT0: begin
                cyc_o    = m0_cyc_i;
                stb_req  = m0_stb_i;
                we_o     = m0_we_i;
                sel_o    = m0_sel_i;
                adr_o    = m0_adr_i;
                dat_o    = m0_dat_i;
                m0_ack_o = ack_i;
            end
            GNT1: begin
                cyc_o    = m1_cyc_i;
                stb_req  = m1_stb_i;
                we_o     = m1_we_i;
                sel_o    = m1_sel_i;
                adr_o    = m1_adr_i;
                dat_o    = m1_dat_i;
                m1_ack_o = ack_i;
            end
            default: ;
        endcase
    end

    assign stb_o    = stb_req & ~tmo_hit;
    assign m0_dat_o = dat_i;
    assign m1_dat_o = dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;

    // Fires on the TMO-th consecutive unacknowledged strobe cycle.
    assign tmo_hit  = stb_req && !ack_i && (tmo_cnt == CW'(TMO - 1));
    assign m0_err_o = tmo_hit && (state == GNT0);
    assign m1_err_o = tmo_hit && (state == GNT1);

    always_ff @(posedge clk_i) begin
        if (rst_i || !stb_req || ack_i || tmo_hit) tmo_cnt <= '0;
        else                                        tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: single transfer, round-robin ties, bus gap, no-preemption burst, reset, timeout.
module tb_wb_arb;
    localparam int AW = 30;
    localparam int DW = 32;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [DW/8-1:0] m0_sel, m1_sel, sel_o;
    logic [AW-1:0]   m0_adr, m1_adr, adr_o;
    logic [DW-1:0]   m0_wdat, m1_wdat, m0_rdat, m1_rdat, dat_o, dat_i;
    logic            m0_ack, m1_ack, cyc_o, stb_o, we_o, ack_i;
`ifdef WB_ARB_TIMEOUT_EN
    logic            m0_err, m1_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wb_arb #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_dat_o(m0_rdat),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_dat_o(m1_rdat),
`ifdef WB_ARB_TIMEOUT_EN
        .m0_err_o(m0_err), .m1_err_o(m1_err),
`endif
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .sel_o(sel_o),
        .adr_o(adr_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, ack_i} = '0;
        m0_sel = '0; m1_sel = '0; m0_adr = '0; m1_adr = '0;
        m0_wdat = '0; m1_wdat = '0; dat_i = '0;
        do_reset();

        // reset state
        chk("rst_cyc", cyc_o, 0);
        chk("rst_stb", stb_o, 0);
        chk("rst_adr", adr_o, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
`ifdef WB_ARB_TIMEOUT_EN
        chk("rst_err", {m0_err, m1_err}, 0);
`endif

        // single m0 read, ack two cycles into the grant
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_sel = 4'hF; m0_adr = 30'h0000100;
        m0_wdat = 32'hCAFE0001;
        #1;
        chk("idle_blocks_cyc", cyc_o, 0);
        tick();
        chk("rd_gnt_cyc", cyc_o, 1);
        chk("rd_adr", adr_o, 30'h0000100);
        chk("rd_sel_we", {sel_o, we_o}, {4'hF, 1'b0});
        chk("rd_dat_o", dat_o, 32'hCAFE0001);
        chk("rd_ack_early", m0_ack, 0);
        tick();
        ack_i = 1; dat_i = 32'hDEADBEEF;
        #1;
        chk("rd_m0_ack", m0_ack, 1);
        chk("rd_m0_dat", m0_rdat, 32'hDEADBEEF);
        chk("rd_m1_ack", m1_ack, 0);
        chk("rd_m1_dat", m1_rdat, 32'hDEADBEEF);
        tick();
        ack_i = 0; m0_cyc = 0; m0_stb = 0;
        #1;
        chk("rd_ack_one_cyc", m0_ack, 0);
        tick();
        chk("rd_back_idle", cyc_o, 0);

        // reset must restore m0 as first tie winner even though m0 was last granted
        do_reset();
        m0_adr = 30'h10; m1_adr = 30'h20;
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        tick();
        chk("tie1_m0", adr_o, 30'h10);
        ack_i = 1;
        #1;
        chk("tie1_m1_noack", m1_ack, 0);
        ack_i = 0;
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("gap_cyc", cyc_o, 0);
        tick();
        chk("after_gap_m1", adr_o, 30'h20);
        chk("after_gap_cyc", cyc_o, 1);

        // m1 last granted -> tie goes to m0
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("m1_release", cyc_o, 0);
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        tick();
        chk("tie2_m0", adr_o, 30'h10);
        // m0 last granted -> next tie goes to m1
        m0_cyc = 0; m1_cyc = 0; m0_stb = 0; m1_stb = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1;
        tick();
        chk("tie3_m1", adr_o, 30'h20);

        // m1 burst of 4 writes while m0 keeps requesting
        m1_we = 1; m1_sel = 4'hF;
        for (int i = 1; i <= 4; i++) begin
            m1_wdat = 32'h11111111 * i;
            ack_i = 1;
            #1;
            chk("burst_dat", dat_o, 32'h11111111 * i);
            chk("burst_owner", adr_o, 30'h20);
            chk("burst_acks", {m0_ack, m1_ack}, 2'b01);
            tick();
        end
        ack_i = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        chk("burst_gap", cyc_o, 0);
        tick();
        chk("burst_then_m0", adr_o, 30'h10);

        // reset mid-transfer in GNT1
        m0_cyc = 0; m0_stb = 0;
        tick();
        m1_cyc = 1; m1_stb = 1;
        tick();
        chk("pre_rst_stb", {cyc_o, stb_o, adr_o}, {2'b11, 30'h20});
        rst = 1;
        tick();
        rst = 0;
        chk("rst_mid_cyc_stb", {cyc_o, stb_o}, 0);
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("rst_mid_tie_m0", adr_o, 30'h10);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();

        // watchdog: m0 strobes with no ack
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int c = 1; c <= 12; c++) begin
`ifdef WB_ARB_TIMEOUT_EN
            chk("tmo_err", {m0_err, m1_err}, (c == TMO) ? 2'b10 : 2'b00);
            chk("tmo_stb", stb_o, (c == TMO) ? 0 : 1);
`else
            chk("wait_stb", stb_o, 1);
`endif
            tick();
        end
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("final_idle", cyc_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
